gshare_pht_scheduler: RTL



---
 rtl/gshare_pht_scheduler_if.sv | 34 +++
 rtl/gshare_pht_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/gshare_pht_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : gshare_pht_scheduler_if
// Description : Lookup, prediction and resolution-update signals between a
//               branch predictor requester (master) and the gshare PHT
//               scheduler (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface gshare_pht_scheduler_if #(
    parameter int IDX_W = 8
);
    logic             lkp_valid;
    logic             lkp_ready;
    logic [IDX_W-1:0] lkp_pc;
    logic             pred_valid;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_index;
    logic             upd_valid;
    logic             upd_ready;
    logic [IDX_W-1:0] upd_index;
    logic             upd_taken;
    logic             upd_pred;

    modport master (
        output lkp_valid, lkp_pc, upd_valid, upd_index, upd_taken, upd_pred,
        input  lkp_ready, pred_valid, pred_taken, pred_index, upd_ready
    );

    modport slave (
        input  lkp_valid, lkp_pc, upd_valid, upd_index, upd_taken, upd_pred,
        output lkp_ready, pred_valid, pred_taken, pred_index, upd_ready
    );
endinterface
`default_nettype wire

// File: rtl/gshare_pht_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : gshare_pht_scheduler
// Description : gshare PHT (2-bit counters) and GHR owner. Arbitrates the
//               single PHT port between lookups and buffered resolution
//               updates, with level/age forced drains and a post-reset
//               init sweep. Optional macro BP_STATS_EN adds 16-bit
//               lookup/update/mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_pht_scheduler #(
    parameter int         PHT_SIZE   = 256,
    parameter int         GHR_WIDTH  = 8,
    parameter logic [1:0] INIT_CTR   = 2'b10,
    parameter int         FIFO_DEPTH = 4,
    parameter int         MAX_WAIT   = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    gshare_pht_scheduler_if.slave      bus,
    output logic                       init_done,
    output logic [15:0]                stat_lookups,
    output logic [15:0]                stat_updates,
    output logic [15:0]                stat_mispredicts
);
    localparam int IDX_W = $clog2(PHT_SIZE);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] C_CNT_HI   = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [AGE_W-1:0] C_AGE_MAX  = AGE_W'(MAX_WAIT);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(PHT_SIZE - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t r_state, w_state_nxt;

    logic [1:0]       r_pht [PHT_SIZE];
    logic [IDX_W-1:0] r_init_ptr;
    // GHR_WIDTH equals IDX_W, so the GHR XORs directly onto the PC
    logic [GHR_WIDTH-1:0] r_ghr;

    logic [IDX_W-1:0]      r_fifo_idx [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_tk;
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [AGE_W-1:0]      r_age;

    logic             r_pred_valid, r_pred_taken;
    logic [IDX_W-1:0] r_pred_index;

    logic             w_run, w_empty, w_full, w_force;
    logic             w_lkp_fire, w_drain, w_push;
    logic [IDX_W-1:0] w_lkp_idx, w_head_idx;
    logic             w_head_tk;
    logic [1:0]       w_head_ctr, w_ctr_upd;

    assign w_run   = (r_state == ST_RUN);
    assign w_empty = (r_count == '0);
    // With one push per cycle the level-forced drain keeps the count below
    // FIFO_DEPTH in practice; the full check still guards the storage.
    assign w_full  = (r_count == C_CNT_FULL);
    assign w_force = !w_empty && ((r_count >= C_CNT_HI) || (r_age >= C_AGE_MAX));

    // Lookup and drain are mutually exclusive: a forced drain masks ready,
    // an unforced drain only happens with no lookup request.
    assign w_lkp_fire = w_run && bus.lkp_valid && !w_force;
    assign w_drain    = w_run && !w_empty && (w_force || !bus.lkp_valid);
    assign w_push     = w_run && bus.upd_valid && !w_full;

    assign w_lkp_idx  = bus.lkp_pc ^ r_ghr;
    assign w_head_idx = r_fifo_idx[r_rd_ptr];
    assign w_head_tk  = r_fifo_tk[r_rd_ptr];
    assign w_head_ctr = r_pht[w_head_idx];

    assign bus.lkp_ready  = w_run && !w_force;
    assign bus.upd_ready  = w_run && !w_full;
    assign bus.pred_valid = r_pred_valid;
    assign bus.pred_taken = r_pred_taken;
    assign bus.pred_index = r_pred_index;

    // State register for the init sweep / run sequencing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave INIT after the last entry is written
    always_comb begin
        w_state_nxt = r_state;
        init_done   = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_init_ptr == C_IDX_LAST) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                init_done = 1'b1;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // Saturating counter step for the FIFO head entry
    always_comb begin
        w_ctr_upd = w_head_ctr;
        if (w_head_tk) begin
            if (w_head_ctr != 2'b11) begin
                w_ctr_upd = w_head_ctr + 2'd1;
            end
        end else if (w_head_ctr != 2'b00) begin
            w_ctr_upd = w_head_ctr - 2'd1;
        end
    end

    // Single PHT write port: init sweep or drained update
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_pht[r_init_ptr] <= INIT_CTR;
        end else if (w_drain) begin
            r_pht[w_head_idx] <= w_ctr_upd;
        end
    end

    // Update FIFO storage
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_idx[r_wr_ptr] <= bus.upd_index;
            r_fifo_tk[r_wr_ptr]  <= bus.upd_taken;
        end
    end

    // Sweep pointer, GHR, FIFO bookkeeping, age and prediction registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_init_ptr   <= '0;
            r_ghr        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_age        <= '0;
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_index <= '0;
        end else begin
            if (!w_run) begin
                r_init_ptr <= r_init_ptr + 1'b1;
            end
            if (w_push) begin
                r_ghr    <= {r_ghr[GHR_WIDTH-2:0], bus.upd_taken};
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_drain) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drain || w_empty) begin
                r_age <= '0;
            end else if (r_age < C_AGE_MAX) begin
                r_age <= r_age + 1'b1;
            end
            r_pred_valid <= w_lkp_fire;
            if (w_lkp_fire) begin
                r_pred_taken <= r_pht[w_lkp_idx][1];
                r_pred_index <= w_lkp_idx;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [15:0] r_stat_lkp, r_stat_upd, r_stat_mis;

    // Wrapping activity counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_lkp <= '0;
            r_stat_upd <= '0;
            r_stat_mis <= '0;
        end else begin
            if (w_lkp_fire) begin
                r_stat_lkp <= r_stat_lkp + 16'd1;
            end
            if (w_push) begin
                r_stat_upd <= r_stat_upd + 16'd1;
                if (bus.upd_pred != bus.upd_taken) begin
                    r_stat_mis <= r_stat_mis + 16'd1;
                end
            end
        end
    end

    assign stat_lookups     = r_stat_lkp;
    assign stat_updates     = r_stat_upd;
    assign stat_mispredicts = r_stat_mis;
`else
    logic w_unused_pred;
    assign w_unused_pred    = bus.upd_pred;
    assign stat_lookups     = '0;
    assign stat_updates     = '0;
    assign stat_mispredicts = '0;
`endif
endmodule
`default_nettype wire
